uart_rx_core: RTL and testbench

- 8N1 UART receiver, the receive-side counterpart of the MCU UART transmit path; feeds the SBUF/RI logic of the serial SFR block.
- Synchronises and glitch-filters the RXD pin, detects the start bit, samples each bit at mid-period and presents the byte with an 8051-style ready flag.
- Reports framing and overrun errors.
- Bit period is programmable in clock cycles so baud can be set at run time between 9600 and 921600 baud at the 96 MHz core clock.

---
 rtl/uart_rx_core_if.sv | 25 ++
 rtl/uart_rx_core.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_if.sv
// Receive-side handshake between the UART receiver and the serial SFR block.
// The receiver drives the byte and status flags; the consumer returns rx_ack.
interface uart_rx_core_if;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       overrun;
    logic       framing_error;
    logic       rx_ack;

    modport master (
        output rx_data,
        output rx_ready,
        output overrun,
        output framing_error,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_ready,
        input  overrun,
        input  framing_error,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronised, glitch-filtered RXD, mid-bit sampling with a
// run-time bit period, 8051-style ready flag plus overrun and framing reporting.
module uart_rx_core #(
    parameter int FILTER_CYCLES = 8,
    parameter int MIN_PERIOD    = 104,
    parameter int PERIOD_WIDTH  = 14
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable_in,
    input  logic [PERIOD_WIDTH-1:0] baud_period,
    input  logic                    rxd,
    uart_rx_core_if.master          rx_bus
);

    localparam int FCW = $clog2(FILTER_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        LOAD,
        BREAK
    } state_t;

    state_t                  state;
    logic                    sync_meta;
    logic                    sync_line;
    logic                    filt;
    logic                    filt_prev;
    logic [FCW-1:0]          filt_cnt;
    logic [PERIOD_WIDTH-1:0] period;
    logic [PERIOD_WIDTH-1:0] cnt;
    logic [PERIOD_WIDTH-1:0] start_period;
    logic [2:0]              bit_idx;
    logic [7:0]              shift_reg;
    logic [7:0]              rx_data_q;
    logic                    rx_ready_q;
    logic                    overrun_q;
    logic                    framing_error_q;
    logic                    filt_fall;
    logic                    sample_now;

    // Too-short periods are raised to the fastest supported rate.
    assign start_period = (baud_period < PERIOD_WIDTH'(MIN_PERIOD)) ?
                          PERIOD_WIDTH'(MIN_PERIOD) : baud_period;
    assign filt_fall    = filt_prev & ~filt;
    assign sample_now   = (cnt == '0);

    assign rx_bus.rx_data       = rx_data_q;
    assign rx_bus.rx_ready      = rx_ready_q;
    assign rx_bus.overrun       = overrun_q;
    assign rx_bus.framing_error = framing_error_q;

    // The filtered line only flips after FILTER_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b1;
            sync_line <= 1'b1;
            filt      <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            sync_meta <= rxd;
            sync_line <= sync_meta;
            filt_prev <= filt;
            if (sync_line != filt) begin
                if (filt_cnt == FCW'(FILTER_CYCLES - 1)) begin
                    filt     <= sync_line;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FCW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            period          <= PERIOD_WIDTH'(MIN_PERIOD);
            cnt             <= '0;
            bit_idx         <= '0;
            shift_reg       <= '0;
            rx_data_q       <= '0;
            rx_ready_q      <= 1'b0;
            overrun_q       <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            framing_error_q <= 1'b0;
            if (rx_bus.rx_ack) begin
                rx_ready_q <= 1'b0;
                overrun_q  <= 1'b0;
            end

            if (!enable_in) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (filt_fall) begin
                            period <= start_period;
                            cnt    <= (start_period >> 1) - PERIOD_WIDTH'(1);
                            state  <= START;
                        end
                    end

                    START: begin
                        if (sample_now) begin
                            cnt <= period - PERIOD_WIDTH'(1);
                            if (!filt) begin
                                bit_idx <= '0;
                                state   <= DATA;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt - PERIOD_WIDTH'(1);
                        end
                    end

                    // Bits arrive LSB first, so shift in from the top.
                    DATA: begin
                        if (sample_now) begin
                            cnt       <= period - PERIOD_WIDTH'(1);
                            shift_reg <= {filt, shift_reg[7:1]};
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            cnt <= cnt - PERIOD_WIDTH'(1);
                        end
                    end

                    STOP: begin
                        if (sample_now) begin
                            if (filt) begin
                                state <= LOAD;
                            end else begin
                                framing_error_q <= 1'b1;
                                state           <= BREAK;
                            end
                        end else begin
                            cnt <= cnt - PERIOD_WIDTH'(1);
                        end
                    end

                    // A coincident rx_ack consumes the old byte, so no overrun then.
                    LOAD: begin
                        rx_data_q  <= shift_reg;
                        rx_ready_q <= 1'b1;
                        overrun_q  <= rx_ready_q & ~rx_bus.rx_ack;
                        state      <= IDLE;
                    end

                    BREAK: begin
                        if (filt) begin
                            state <= IDLE;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed self-checking bench for uart_rx_core: timing, filtering, framing,
// overrun, clamped baud and mid-frame reset.
module tb_uart_rx_core;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable_in;
    logic [13:0] baud_period;
    logic        rxd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int ready_rises = 0;
    int fe_pulses = 0;
    int fe_cycles = 0;
    logic fe_prev = 1'b0;
    logic rdy_prev = 1'b0;
    logic seen_c3 = 1'b0;

    uart_rx_core_if bus ();

    uart_rx_core #(
        .FILTER_CYCLES (8),
        .MIN_PERIOD    (104),
        .PERIOD_WIDTH  (14)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable_in   (enable_in),
        .baud_period (baud_period),
        .rxd         (rxd),
        .rx_bus      (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation is done on the falling edge, away from the sampling edge.
    always @(negedge clk) begin
        if (bus.framing_error) fe_cycles++;
        if (bus.framing_error && !fe_prev) fe_pulses++;
        fe_prev = bus.framing_error;
        if (bus.rx_ready && !rdy_prev) begin
            ready_rises++;
            rise_cyc = cyc;
        end
        rdy_prev = bus.rx_ready;
        if (bus.rx_ready && bus.rx_data == 8'hC3) seen_c3 = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one full 8N1 frame, one clock per loop step; optional rx_ack and reset
    // events are placed at a given clock index within the frame.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                 input int bit_len, input int ack_idx,
                                 input int rst_idx, output int start_cyc);
        int b;
        start_cyc = cyc;
        for (int i = 0; i < 10 * bit_len; i++) begin
            b = i / bit_len;
            if (b == 0) rxd = 1'b0;
            else if (b <= 8) rxd = data[b-1];
            else rxd = stop_bit;
            bus.rx_ack = (i == ack_idx);
            if (i == rst_idx) reset_n = 1'b0;
            tick(1);
        end
        rxd = 1'b1;
        bus.rx_ack = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.rx_ack = 1'b1;
        tick(1);
        bus.rx_ack = 1'b0;
    endtask

    initial begin
        int t0;
        int r0;
        int f0;
        int fc0;

        reset_n     = 1'b0;
        enable_in   = 1'b1;
        baud_period = 14'd833;
        rxd         = 1'b1;
        bus.rx_ack  = 1'b0;
        tick(3);
        checkOutput("reset_rx_data", 32'(bus.rx_data), 32'h00);
        checkOutput("reset_rx_ready", 32'(bus.rx_ready), 32'h0);
        checkOutput("reset_overrun", 32'(bus.overrun), 32'h0);
        checkOutput("reset_framing_error", 32'(bus.framing_error), 32'h0);
        reset_n = 1'b1;
        tick(20);

        // 0xA5 at 833 clocks per bit: ready one clock after the stop sample.
        applyStimulus(8'hA5, 1'b1, 833, -1, -1, t0);
        checkOutput("a5_latency_window",
                    32'((rise_cyc - t0) >= 7922 && (rise_cyc - t0) <= 7926), 32'h1);
        checkOutput("a5_rx_data", 32'(bus.rx_data), 32'hA5);
        checkOutput("a5_rx_ready", 32'(bus.rx_ready), 32'h1);
        checkOutput("a5_overrun", 32'(bus.overrun), 32'h0);
        checkOutput("a5_fe_pulses", 32'(fe_pulses), 32'h0);
        ack_pulse();
        checkOutput("a5_ack_clears_ready", 32'(bus.rx_ready), 32'h0);

        // Glitch shorter than the filter, then a false start.
        r0 = ready_rises;
        f0 = fe_pulses;
        rxd = 1'b0;
        tick(5);
        rxd = 1'b1;
        tick(100);
        rxd = 1'b0;
        tick(200);
        rxd = 1'b1;
        tick(1000);
        checkOutput("glitch_no_ready", 32'(ready_rises), 32'(r0));
        checkOutput("glitch_no_fe", 32'(fe_pulses), 32'(f0));

        // Bad stop bit, then a good frame.
        baud_period = 14'd104;
        f0  = fe_pulses;
        fc0 = fe_cycles;
        applyStimulus(8'h3C, 1'b0, 104, -1, -1, t0);
        tick(100);
        checkOutput("fe_one_pulse", 32'(fe_pulses), 32'(f0 + 1));
        checkOutput("fe_one_cycle", 32'(fe_cycles), 32'(fc0 + 1));
        checkOutput("fe_rx_ready", 32'(bus.rx_ready), 32'h0);
        checkOutput("fe_rx_data_held", 32'(bus.rx_data), 32'hA5);
        applyStimulus(8'h55, 1'b1, 104, -1, -1, t0);
        tick(5);
        checkOutput("after_fe_rx_data", 32'(bus.rx_data), 32'h55);
        checkOutput("after_fe_rx_ready", 32'(bus.rx_ready), 32'h1);
        ack_pulse();

        // Overrun without ack, cleared by ack.
        applyStimulus(8'h11, 1'b1, 104, -1, -1, t0);
        applyStimulus(8'h22, 1'b1, 104, -1, -1, t0);
        checkOutput("ovr_rx_data", 32'(bus.rx_data), 32'h22);
        checkOutput("ovr_rx_ready", 32'(bus.rx_ready), 32'h1);
        checkOutput("ovr_overrun", 32'(bus.overrun), 32'h1);
        ack_pulse();
        checkOutput("ovr_ack_ready", 32'(bus.rx_ready), 32'h0);
        checkOutput("ovr_ack_overrun", 32'(bus.overrun), 32'h0);

        // rx_ack lands on the completion edge: 11 + 52 + 9*104 clocks into the frame.
        applyStimulus(8'h11, 1'b1, 104, -1, -1, t0);
        applyStimulus(8'h22, 1'b1, 104, 999, -1, t0);
        checkOutput("coinc_rx_data", 32'(bus.rx_data), 32'h22);
        checkOutput("coinc_rx_ready", 32'(bus.rx_ready), 32'h1);
        checkOutput("coinc_overrun", 32'(bus.overrun), 32'h0);
        ack_pulse();

        // Period below the minimum is clamped to 104; frames back to back.
        baud_period = 14'd50;
        f0 = fe_pulses;
        applyStimulus(8'h00, 1'b1, 104, -1, -1, t0);
        checkOutput("clamp0_rx_data", 32'(bus.rx_data), 32'h00);
        checkOutput("clamp0_rx_ready", 32'(bus.rx_ready), 32'h1);
        checkOutput("clamp0_overrun", 32'(bus.overrun), 32'h0);
        applyStimulus(8'hFF, 1'b1, 104, 0, -1, t0);
        checkOutput("clamp1_rx_data", 32'(bus.rx_data), 32'hFF);
        checkOutput("clamp1_rx_ready", 32'(bus.rx_ready), 32'h1);
        checkOutput("clamp1_overrun", 32'(bus.overrun), 32'h0);
        applyStimulus(8'h81, 1'b1, 104, 0, -1, t0);
        checkOutput("clamp2_rx_data", 32'(bus.rx_data), 32'h81);
        checkOutput("clamp2_rx_ready", 32'(bus.rx_ready), 32'h1);
        checkOutput("clamp2_overrun", 32'(bus.overrun), 32'h0);
        checkOutput("clamp_no_fe", 32'(fe_pulses), 32'(f0));

        // Reset asserted in the middle of data bit 3 and held to the end of the frame.
        baud_period = 14'd104;
        applyStimulus(8'hC3, 1'b1, 104, -1, 468, t0);
        checkOutput("rst_rx_data", 32'(bus.rx_data), 32'h00);
        checkOutput("rst_rx_ready", 32'(bus.rx_ready), 32'h0);
        checkOutput("rst_overrun", 32'(bus.overrun), 32'h0);
        checkOutput("rst_framing_error", 32'(bus.framing_error), 32'h0);
        reset_n = 1'b1;
        tick(20);
        applyStimulus(8'h7E, 1'b1, 104, -1, -1, t0);
        checkOutput("post_rst_rx_data", 32'(bus.rx_data), 32'h7E);
        checkOutput("post_rst_rx_ready", 32'(bus.rx_ready), 32'h1);
        checkOutput("post_rst_overrun", 32'(bus.overrun), 32'h0);
        checkOutput("c3_never_reported", 32'(seen_c3), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
